// File: rtl/diff_io_pkg.sv
// diff_io_pkg: shared types and limits for the differential-input helpers
package diff_io_pkg;

    typedef enum logic {
        S_STABLE = 1'b0,
        S_CHECK  = 1'b1
    } state_e;

    localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: plain flop chain bringing an async bit into clk
//   clk, rst (async, active-high) ; d_i async input ; q_o synchronized output
module sync_ff
    import diff_io_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
        $error("sync_ff: STAGES must be >= %0d", MIN_SYNC_STAGES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/diff_in_debounce.sv
// diff_in_debounce: synchronize and debounce an IBUFDS output, report level and edges
//   clk, rst (async, active-high) ; din async input
//   level debounced level ; rise/fall one-cycle commit pulses ; toggle flips per rise
//   busy high while qualifying a change ; edge_count wrapping count of rises
module diff_in_debounce
    import diff_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             toggle,
    output logic             busy,
    output logic [CNT_W-1:0] edge_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("diff_in_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             s;
    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             toggle_q;
    logic             busy_q;
    logic [CNT_W-1:0] count_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (din),
        .q_o (s)
    );

    // The candidate is always ~level, so "s matches candidate" is s != level_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_STABLE;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                S_STABLE: begin
                    if (s != level_q) begin
                        state_q <= S_CHECK;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(1);
                    end
                end
                S_CHECK: begin
                    if (s == level_q) begin
                        state_q <= S_STABLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q <= S_STABLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        level_q <= s;
                        rise_q  <= s;
                        fall_q  <= ~s;
                        if (s) begin
                            toggle_q <= ~toggle_q;
                            count_q  <= count_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_STABLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign toggle     = toggle_q;
    assign busy       = busy_q;
    assign edge_count = count_q;

endmodule

// File: tb/tb_diff_in_debounce.sv
// tb_diff_in_debounce: directed self-checking bench for diff_in_debounce
module tb_diff_in_debounce;

    logic       clk;
    logic       rst;
    logic       din;
    logic       level;
    logic       rise;
    logic       fall;
    logic       toggle;
    logic       busy;
    logic [7:0] edge_count;
    logic [12:0] outs;

    int checks = 0;
    int errors = 0;
    logic       tg = 1'b0;
    logic [7:0] cn = 8'd0;

    diff_in_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .toggle     (toggle),
        .busy       (busy),
        .edge_count (edge_count)
    );

    assign outs = {level, rise, fall, toggle, busy, edge_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] ex(input logic lv, input logic r, input logic f, input logic b);
        return {lv, r, f, tg, b, cn};
    endfunction

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive din to v (pipeline holding ~v) and follow the full 6-edge qualification.
    task automatic run_commit(input string tag, input logic v);
        din = v;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            chk(tag, outs, ex(~v, 1'b0, 1'b0, e >= 3));
        end
        tick(1);
        if (v) begin
            tg = ~tg;
            cn = cn + 8'd1;
        end
        chk(tag, outs, ex(v, v, ~v, 1'b0));
        tick(1);
        chk(tag, outs, ex(v, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        logic [1:6]  pat;
        logic [1:10] bb;
        logic        t0;
        logic [7:0]  c0;
        pat = 6'b101101;
        bb  = 10'b0010110111;
        rst = 1'b1;
        din = 1'b0;
        #2;
        chk("reset_initial", outs, 13'd0);
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle", outs, 13'd0);
        end
        din = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            if (e == 4) din = 1'b0;
            tick(1);
            chk("short_pulse", outs, ex(1'b0, 1'b0, 1'b0, e >= 3));
        end
        tick(1);
        chk("short_abort", outs, ex(1'b0, 1'b0, 1'b0, 1'b0));
        tick(4);
        chk("short_idle", outs, ex(1'b0, 1'b0, 1'b0, 1'b0));
        run_commit("rise", 1'b1);
        run_commit("fall", 1'b0);
        tick(2);
        for (int e = 1; e <= 10; e++) begin
            din = (e <= 6) ? pat[e] : 1'b1;
            tick(1);
            chk("bounce", outs, ex(1'b0, 1'b0, 1'b0, bb[e]));
        end
        tick(1);
        tg = ~tg;
        cn = cn + 8'd1;
        chk("bounce_rise", outs, ex(1'b1, 1'b1, 1'b0, 1'b0));
        tick(1);
        chk("bounce_end", outs, ex(1'b1, 1'b0, 1'b0, 1'b0));
        run_commit("bounce_fall", 1'b0);
        t0 = tg;
        c0 = cn;
        for (int k = 0; k < 256; k++) begin
            run_commit("wrap_rise", 1'b1);
            if (cn == 8'd0) chk("wrap_zero", {5'd0, edge_count}, 13'd0);
            run_commit("wrap_fall", 1'b0);
        end
        chk("wrap_final", {4'd0, toggle, edge_count}, {4'd0, t0, c0});
        din = 1'b1;
        tick(4);
        chk("mid_busy", outs, ex(1'b0, 1'b0, 1'b0, 1'b1));
        rst = 1'b1;
        #2;
        tg = 1'b0;
        cn = 8'd0;
        chk("reset_async", outs, 13'd0);
        tick(2);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            chk("post_reset", outs, ex(1'b0, 1'b0, 1'b0, e >= 3));
        end
        tick(1);
        tg = ~tg;
        cn = cn + 8'd1;
        chk("post_reset_rise", outs, ex(1'b1, 1'b1, 1'b0, 1'b0));
        tick(1);
        chk("post_reset_end", outs, ex(1'b1, 1'b0, 1'b0, 1'b0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
